// File: rtl/idfwd_pkg.sv
`default_nettype none
// ============================================================================
// Package : idfwd_pkg -- shared types/constants for the ID-stage forwarding unit
// Rev     : 1.0
// ============================================================================
package idfwd_pkg;

    // Tracker entries store destinations at this width; REG_AW must not exceed it.
    localparam int ENT_AW = 8;

    localparam int STG_RF  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    typedef struct packed {
        logic              valid;
        logic [ENT_AW-1:0] dst;
        logic              is_load;
    } entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    function automatic logic result_ready(input logic is_load, input int stage,
                                          input int load_ready);
        return !is_load || (stage >= load_ready);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idfwd_src_match.sv
`default_nettype none
// ============================================================================
// Module : idfwd_src_match -- nearest-producer match for one ID source operand
// Rev    : 1.0
// ============================================================================
module idfwd_src_match
    import idfwd_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SELW       = 2
) (
    input  entry_t [DEPTH-1:0] trk,
    input  logic [REG_AW-1:0]  src,
    input  logic               src_use,
    output logic [SELW-1:0]    sel,
    output logic               hazard
);

    logic found;

    // trk[0] is the EX stage; the first hit is the youngest producer.
    always_comb begin
        sel    = SELW'(STG_RF);
        hazard = 1'b0;
        found  = 1'b0;
        if (src_use && (src != '0)) begin
            for (int k = STG_EX; k <= DEPTH; k++) begin
                if (!found && trk[k-1].valid && (trk[k-1].dst == ENT_AW'(src))) begin
                    found = 1'b1;
                    if (result_ready(trk[k-1].is_load, k, LOAD_READY)) begin
                        sel = SELW'(k);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_branch_fwd_tracker.sv
`default_nettype none
// ============================================================================
// Module : id_branch_fwd_tracker -- ID-stage branch/JR forwarding and hazard unit
//          Optional stall accounting (FSM + stall_cnt) under IDFWD_STALL_CNT_EN.
// Rev    : 1.0
// ============================================================================
module id_branch_fwd_tracker
    import idfwd_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   id_valid,
    input  logic                                   id_early,
    input  logic [NUM_SRC*REG_AW-1:0]              id_src,
    input  logic [NUM_SRC-1:0]                     id_src_use,
    input  logic                                   id_wr_en,
    input  logic [REG_AW-1:0]                      id_wr_dst,
    input  logic                                   id_is_load,
    input  logic                                   ex_flush,
    input  logic                                   pipe_hold,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
    output logic                                   stall_out,
    output logic [15:0]                            stall_cnt
);

    localparam int SELW = $clog2(DEPTH+1);

    entry_t [DEPTH-1:0] trk;
    entry_t             new_ent;
    logic [NUM_SRC-1:0] hazard;

    // A stalled or flushed ID instruction enters EX as a bubble.
    always_comb begin
        new_ent = '0;
        if (id_valid && id_wr_en && (id_wr_dst != '0) && !stall_out && !ex_flush) begin
            new_ent.valid   = 1'b1;
            new_ent.dst     = ENT_AW'(id_wr_dst);
            new_ent.is_load = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk <= '0;
        end else if (!pipe_hold) begin
            for (int k = DEPTH-1; k > 0; k--) begin
                trk[k] <= trk[k-1];
            end
            trk[0] <= new_ent;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        idfwd_src_match #(
            .REG_AW     (REG_AW),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_match (
            .trk     (trk),
            .src     (id_src[i*REG_AW +: REG_AW]),
            .src_use (id_valid & id_early & id_src_use[i]),
            .sel     (fwd_sel[i*SELW +: SELW]),
            .hazard  (hazard[i])
        );
    end

    assign stall_out = |hazard;

`ifdef IDFWD_STALL_CNT_EN
    fsm_state_t  state;
    fsm_state_t  state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!pipe_hold) begin
            case (state)
                RUN:     if (stall_out)  state_nx = STALL;
                STALL:   if (!stall_out) state_nx = RUN;
                default: state_nx = RUN;
            endcase
            if (stall_out && (cnt != 16'hFFFF)) begin
                cnt_nx = cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_branch_fwd_tracker.sv
`default_nettype none
// Bench for id_branch_fwd_tracker: directed scenarios plus random traffic,
// checked by a scoreboard against a queue-based model of the pipeline.
module tb_id_branch_fwd_tracker;

    localparam int REG_AW     = 5;
    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_early = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
    logic [9:0]  id_src = '0;
    logic [1:0]  id_src_use = '0;
    logic [4:0]  id_wr_dst = '0;
    logic        ex_flush = 1'b0, pipe_hold = 1'b0;
    logic [3:0]  fwd_sel;
    logic        stall_out;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    id_branch_fwd_tracker #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_early(id_early),
        .id_src(id_src), .id_src_use(id_src_use), .id_wr_en(id_wr_en),
        .id_wr_dst(id_wr_dst), .id_is_load(id_is_load), .ex_flush(ex_flush),
        .pipe_hold(pipe_hold), .fwd_sel(fwd_sel), .stall_out(stall_out),
        .stall_cnt(stall_cnt)
    );

    typedef struct { bit valid; int dst; bit ld; } pent_t;
    typedef struct { logic [3:0] sel; logic stall; logic [15:0] cnt; int id; } exp_t;

    pent_t       pipe[$];   // pipe[0] = instruction now in EX
    exp_t        sb[$];
    int unsigned m_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          n_issued = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (item %0d): actual=%0h required=%0h", name, id, act, exp);
        end
    endtask

    // Expected outputs for the ID instruction given the in-flight producers.
    function automatic void model_eval(input int s0, input int s1, input bit [1:0] su,
                                       input bit v, input bit e,
                                       output bit [3:0] sel, output bit stall);
        int s;
        sel = '0;
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? s0 : s1;
            if (v && e && su[i] && s != 0) begin
                for (int k = 0; k < pipe.size(); k++) begin
                    if (pipe[k].valid && pipe[k].dst == s) begin
                        if (!pipe[k].ld || (k + 1) >= LOAD_READY) sel[i*2 +: 2] = 2'(k + 1);
                        else stall = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic issue(input bit v, input bit e, input int s0, input int s1,
                         input bit [1:0] su, input bit wr, input int dst, input bit ld,
                         input bit fl, input bit hd);
        bit [3:0] sel;
        bit       stall;
        exp_t     x;
        pent_t    p;
        id_valid   = v;
        id_early   = e;
        id_src     = {5'(s1), 5'(s0)};
        id_src_use = su;
        id_wr_en   = wr;
        id_wr_dst  = 5'(dst);
        id_is_load = ld;
        ex_flush   = fl;
        pipe_hold  = hd;
        model_eval(s0, s1, su, v, e, sel, stall);
        x.sel = sel; x.stall = stall; x.cnt = 16'(m_cnt); x.id = n_issued++;
        sb.push_back(x);
        if (!hd) begin
            p.valid = v && wr && dst != 0 && !stall && !fl;
            p.dst   = p.valid ? dst : 0;
            p.ld    = p.valid ? ld : 1'b0;
            pipe.push_front(p);
            if (pipe.size() > DEPTH) void'(pipe.pop_back());
`ifdef IDFWD_STALL_CNT_EN
            if (stall && m_cnt < 65535) m_cnt++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input int d);  issue(1, 0, 0, 0, 2'b00, 1, d, 0, 0, 0); endtask
    task automatic lw(input int d);   issue(1, 0, 0, 0, 2'b00, 1, d, 1, 0, 0); endtask
    task automatic nop();             issue(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); endtask
    task automatic beq(input int a, input int b); issue(1, 1, a, b, 2'b11, 0, 0, 0, 0, 0); endtask
    task automatic jr(input int a, input bit hd); issue(1, 1, a, 0, 2'b01, 0, 0, 0, 0, hd); endtask

    task automatic idle_inputs();
        id_valid = 0; id_early = 0; id_src = '0; id_src_use = '0; id_wr_en = 0;
        id_wr_dst = '0; id_is_load = 0; ex_flush = 0; pipe_hold = 0;
    endtask

    task automatic model_reset();
        pipe.delete();
        m_cnt = 0;
    endtask

    // Monitor: outputs are combinational, so one expectation per issued cycle.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                x = sb.pop_front();
                chk("fwd_sel", x.id, 32'(fwd_sel), 32'(x.sel));
                chk("stall_out", x.id, 32'(stall_out), 32'(x.stall));
                chk("stall_cnt", x.id, 32'(stall_cnt), 32'(x.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", -1, 32'(stall_out), 32'd0);
        chk("reset_cnt", -1, 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        beq(1, 2);
        alu(3); beq(3, 4);
        alu(3); nop(); beq(3, 4);
        alu(3); nop(); nop(); beq(3, 4);
        lw(5); jr(5, 0); jr(5, 0);
        alu(6); lw(6); beq(6, 0); beq(6, 0);
        alu(0); beq(0, 0);
        lw(5); jr(5, 1); jr(5, 1); jr(5, 1); jr(5, 0); jr(5, 0);
        issue(1, 0, 0, 0, 2'b00, 1, 7, 0, 1, 0); beq(7, 0);

        // Asynchronous reset while a load-use stall is being presented.
        nop(); nop(); nop();
        lw(8);
        id_valid = 1; id_early = 1; id_src = {5'd0, 5'd8}; id_src_use = 2'b01;
        #1;
        chk("pre_reset_stall", -2, 32'(stall_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_stall", -2, 32'(stall_out), 32'd0);
        chk("async_reset_sel", -2, 32'(fwd_sel), 32'd0);
        chk("async_reset_cnt", -2, 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        beq(1, 2);

        for (int n = 0; n < 500; n++) begin
            issue($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1,
                  $urandom_range(7, 0), $urandom_range(7, 0), 2'($urandom_range(3, 0)),
                  $urandom_range(9, 0) < 7, $urandom_range(7, 0),
                  $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0,
                  $urandom_range(19, 0) < 3);
        end

        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
